ysyx_24110006_muldiv: RTL and testbench

//   Iterative RV32M/RV64M multiply-divide unit, XLEN-parametrised; sibling of the EXU ALU.

---
 rtl/ysyx_24110006_muldiv.sv | 205 ++++++++++++++++++++
 tb/tb_ysyx_24110006_muldiv.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24110006_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ysyx_24110006_muldiv                                         |
// | Description : Iterative RV32M/RV64M multiply/divide unit. Handles one bit   |
// |               per cycle (shift-add multiply, restoring divide) and uses a   |
// |               valid/ready handshake on both sides. The result is held       |
// |               until it is accepted. i_flush aborts any operation in flight. |
// |               Optional macro MULDIV_FAST_MUL_EN: MUL* use a single-cycle    |
// |               '*' multiplier; divide stays iterative.                       |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module ysyx_24110006_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  // Latched operation context
  logic [2:0]       op_q;
  logic [XLEN:0]    acc;      // product high half / partial remainder
  logic [XLEN-1:0]  lo;       // multiplier / dividend, shifts into product low / quotient
  logic [XLEN-1:0]  opnd;     // multiplicand / divisor magnitude
  logic             neg_q;    // negate product or quotient at the end
  logic             neg_r;    // negate remainder at the end
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  result;

  // Request decode
  logic            is_div_in;
  logic            sgn_a_in;
  logic            sgn_b_in;
  logic            neg_a_in;
  logic            neg_b_in;
  logic            b_zero;
  logic            div_ovf;
  logic            fast_in;
  logic            accept;
  logic            last;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic [XLEN-1:0] fast_res;

  // One iteration step
  logic [XLEN-1:0]   addend;
  logic [XLEN:0]     msum;
  logic [XLEN:0]     shifted;
  logic [XLEN+1:0]   diff;
  logic              ge;
  logic [XLEN:0]     acc_nx;
  logic [XLEN-1:0]   lo_nx;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   final_res;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
`endif

  assign is_div_in = i_op[2];
  // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM
  assign sgn_a_in  = (i_op == 3'd1) || (i_op == 3'd2) || (i_op == 3'd4) || (i_op == 3'd6);
  assign sgn_b_in  = (i_op == 3'd1) || (i_op == 3'd4) || (i_op == 3'd6);
  assign neg_a_in  = sgn_a_in & i_a[XLEN-1];
  assign neg_b_in  = sgn_b_in & i_b[XLEN-1];
  assign abs_a     = neg_a_in ? -i_a : i_a;
  assign abs_b     = neg_b_in ? -i_b : i_b;
  assign b_zero    = (i_b == '0);
  assign div_ovf   = is_div_in & sgn_b_in & (i_a == XMIN) & (i_b == '1);
  assign accept    = (state == S_IDLE) & i_valid & ~i_flush;
  assign last      = (cnt == CNT_W'(XLEN-1));

`ifdef MULDIV_FAST_MUL_EN
  assign fast_prod = {{XLEN{neg_a_in}}, i_a} * {{XLEN{neg_b_in}}, i_b};
  assign fast_in   = ~is_div_in | b_zero | div_ovf;
`else
  assign fast_in   = is_div_in & (b_zero | div_ovf);
`endif

  // Results that bypass iteration: divide-by-zero, signed overflow, fast multiply
  always_comb begin
    fast_res = '0;
    if (is_div_in) begin
      if (b_zero) begin
        fast_res = i_op[1] ? i_a : '1;
      end else if (div_ovf) begin
        fast_res = i_op[1] ? '0 : i_a;
      end
    end
`ifdef MULDIV_FAST_MUL_EN
    else begin
      fast_res = (i_op[1:0] == 2'd0) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif
  end

  // One shift-add or restoring-subtract step plus sign fix-up of the final value
  always_comb begin
    addend  = lo[0] ? opnd : '0;
    msum    = acc + {1'b0, addend};
    shifted = {acc[XLEN-1:0], lo[XLEN-1]};
    diff    = {1'b0, shifted} - {2'b00, opnd};
    ge      = ~diff[XLEN+1];
    if (op_q[2]) begin
      acc_nx = ge ? diff[XLEN:0] : shifted;
      lo_nx  = {lo[XLEN-2:0], ge};
    end else begin
      acc_nx = {1'b0, msum[XLEN:1]};
      lo_nx  = {msum[0], lo[XLEN-1:1]};
    end
    prod   = {acc_nx[XLEN-1:0], lo_nx};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -lo_nx : lo_nx;
    rem_s  = neg_r ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
    if (op_q[2]) begin
      final_res = op_q[1] ? rem_s : quo_s;
    end else begin
      final_res = (op_q[1:0] == 2'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; flush overrides everything, including a new request
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (i_valid) state_nx = fast_in ? S_DONE : S_CALC;
      S_CALC: if (last) state_nx = S_DONE;
      S_DONE: if (i_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (i_flush) begin
      state_nx = S_IDLE;
    end
  end

  // Datapath: latch operands on accept, iterate in CALC, register the result
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      op_q   <= '0;
      acc    <= '0;
      lo     <= '0;
      opnd   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else if (accept) begin
      op_q  <= i_op;
      acc   <= '0;
      lo    <= abs_a;
      opnd  <= abs_b;
      neg_q <= neg_a_in ^ neg_b_in;
      neg_r <= neg_a_in;
      cnt   <= '0;
      if (fast_in) begin
        result <= fast_res;
      end
    end else if ((state == S_CALC) && !i_flush) begin
      acc <= acc_nx;
      lo  <= lo_nx;
      cnt <= cnt + CNT_W'(1);
      if (last) begin
        result <= final_res;
      end
    end
  end

  assign o_ready  = (state == S_IDLE);
  assign o_valid  = (state == S_DONE);
  assign o_result = result;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24110006_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ysyx_24110006_muldiv                                      |
// | Description : Self-checking bench for the multiply/divide unit, XLEN=32.    |
// |               Table of directed vectors, random vectors against a          |
// |               reference model, and hand-written handshake/flush/reset      |
// |               sequences. Honors MULDIV_FAST_MUL_EN for MUL* latency.        |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_ysyx_24110006_muldiv;

  localparam logic [31:0] XMIN = 32'h8000_0000;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_flush;
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  ysyx_24110006_muldiv #(.XLEN(32)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_op    (i_op),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_result(o_result)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0]        u;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0]        r;
    sa = a;
    sb = b;
    u  = '0;
    r  = '0;
    case (op)
      3'd0: begin u = {32'b0, a} * {32'b0, b}; r = u[31:0]; end
      3'd1: begin u = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = u[63:32]; end
      3'd2: begin u = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); r = u[63:32]; end
      3'd3: begin u = {32'b0, a} * {32'b0, b}; r = u[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ((a == XMIN && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb));
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ((a == XMIN && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    if (!op[2]) return MUL_LAT;
    if (b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == XMIN && b == 32'hFFFF_FFFF) return 1;
    return DIV_LAT;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Issue one request, measure latency to o_valid, compare against the scoreboard.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input bit hold);
    int edges;
    logic [31:0] e;
    check({name, " ready"}, 32'(o_ready), 32'd1);
    i_op    = op;
    i_a     = a;
    i_b     = b;
    i_valid = 1'b1;
    exp_q.push_back(exp);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_op    = 3'($urandom);
    i_a     = $urandom;
    i_b     = $urandom;
    edges   = 1;
    while (!o_valid && edges < 100) begin
      @(negedge i_clk);
      edges++;
    end
    if (!o_valid) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: got no o_valid after %0d edges, required %0d", name, edges, lat);
      void'(exp_q.pop_front());
      i_flush = 1'b1;
      @(negedge i_clk);
      i_flush = 1'b0;
      return;
    end
    check({name, " latency"}, 32'(edges), 32'(lat));
    e = exp_q.pop_front();
    check({name, " result"}, o_result, e);
    if (!hold) begin
      i_ready = 1'b1;
      @(negedge i_clk);
      i_ready = 1'b0;
      check({name, " back to idle"}, {30'b0, o_ready, o_valid}, 32'b10);
    end
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    bit          seen;

    i_rst_n = 1'b0;
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_op    = '0;
    i_a     = '0;
    i_b     = '0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;

    check("reset o_ready", 32'(o_ready), 32'd1);
    check("reset o_valid", 32'(o_valid), 32'd0);
    check("reset o_result", o_result, 32'd0);

    vecs.push_back('{"MUL 7*-3",        3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT});
    vecs.push_back('{"MULH min*min",    3'd1, XMIN,         XMIN,          32'h4000_0000, MUL_LAT});
    vecs.push_back('{"MULHSU -1*max",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT});
    vecs.push_back('{"MULHU max*max",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT});
    vecs.push_back('{"MULH -2*3",       3'd1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, MUL_LAT});
    vecs.push_back('{"MULHU 2^16*2^16", 3'd3, 32'h0001_0000, 32'h0001_0000, 32'd1,        MUL_LAT});
    vecs.push_back('{"MUL 2^16*2^16",   3'd0, 32'h0001_0000, 32'h0001_0000, 32'd0,        MUL_LAT});
    vecs.push_back('{"DIV -7/2",        3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, DIV_LAT});
    vecs.push_back('{"REM -7/2",        3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, DIV_LAT});
    vecs.push_back('{"DIVU 100/7",      3'd5, 32'd100,      32'd7,         32'd14,        DIV_LAT});
    vecs.push_back('{"REMU 100/7",      3'd7, 32'd100,      32'd7,         32'd2,         DIV_LAT});
    vecs.push_back('{"DIV 7/-2",        3'd4, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT});
    vecs.push_back('{"REM 7/-2",        3'd6, 32'd7,        32'hFFFF_FFFE, 32'd1,         DIV_LAT});
    vecs.push_back('{"REM -7/-2",       3'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, DIV_LAT});
    vecs.push_back('{"DIVU min/max",    3'd5, XMIN,         32'hFFFF_FFFF, 32'd0,         DIV_LAT});
    vecs.push_back('{"DIVU max/1",      3'd5, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, DIV_LAT});
    vecs.push_back('{"DIVU x/0",        3'd5, 32'h1234,     32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{"REM x/0",         3'd6, 32'h1234,     32'd0,         32'h1234,      1});
    vecs.push_back('{"DIV 0/0",         3'd4, 32'd0,        32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{"REMU max/0",      3'd7, 32'hFFFF_FFFF, 32'd0,        32'hFFFF_FFFF, 1});
    vecs.push_back('{"DIV overflow",    3'd4, XMIN,         32'hFFFF_FFFF, XMIN,          1});
    vecs.push_back('{"REM overflow",    3'd6, XMIN,         32'hFFFF_FFFF, 32'd0,         1});

    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b0);
    end

    for (int i = 0; i < 16; i++) begin
      rop = 3'(i % 8);
      ra  = $urandom;
      rb  = (i >= 8) ? 32'($urandom_range(1, 1000)) : $urandom;
      run_op("random", rop, ra, rb, model(rop, ra, rb), model_lat(rop, ra, rb), 1'b0);
    end

    // Consumer stalls in DONE: result held, new requests ignored
    run_op("stall DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14, DIV_LAT, 1'b1);
    for (int k = 0; k < 5; k++) begin
      i_valid = k[0];
      i_op    = 3'd3;
      i_a     = 32'd5;
      i_b     = 32'd6;
      @(negedge i_clk);
      check("stall o_valid", 32'(o_valid), 32'd1);
      check("stall o_result", o_result, 32'd14);
      check("stall o_ready", 32'(o_ready), 32'd0);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    repeat (3) begin
      @(negedge i_clk);
      check("stall not queued", {30'b0, o_ready, o_valid}, 32'b10);
    end

    // Flush at CALC cnt=10
    i_op = 3'd5; i_a = 32'hFFFF; i_b = 32'd1; i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (10) @(negedge i_clk);
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    check("flush o_ready", 32'(o_ready), 32'd1);
    check("flush o_valid", 32'(o_valid), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge i_clk);
      if (o_valid) seen = 1'b1;
    end
    check("flush no late valid", 32'(seen), 32'd0);
    run_op("after flush DIVU 9/3", 3'd5, 32'd9, 32'd3, 32'd3, DIV_LAT, 1'b0);

    // Flush wins over a simultaneous request (fast-path op would otherwise complete)
    i_op = 3'd5; i_a = 32'd5; i_b = 32'd0; i_valid = 1'b1; i_flush = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0; i_flush = 1'b0;
    check("flush beats valid", {30'b0, o_ready, o_valid}, 32'b10);

    // Reset in the middle of CALC
    i_op = 3'd4; i_a = 32'd1000; i_b = 32'd3; i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (6) @(negedge i_clk);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    check("midcalc reset o_ready", 32'(o_ready), 32'd1);
    check("midcalc reset o_valid", 32'(o_valid), 32'd0);
    check("midcalc reset o_result", o_result, 32'd0);
    run_op("after reset DIV 1000/3", 3'd4, 32'd1000, 32'd3, 32'd333, DIV_LAT, 1'b0);

    check("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
